wb_xbar_rr: RTL and testbench

WB_XBAR_RR -- requirements
Module: wb_xbar_rr

---
 rtl/wb_xbar_rr.sv | 241 ++++++++++++++++++++++++
 tb/tb_wb_xbar_rr.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_xbar_rr.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wb_xbar_rr -- Wishbone crossbar with one round-robin arbiter per slave port.
//
// Each master address is decoded against per-slave [start, end) windows. The
// lowest slave index wins on overlap. An address that hits no window goes to
// an internal default slave, which answers every strobe with a one-cycle err.
// Every slave has its own IDLE/OWNED arbiter, so different masters can reach
// different slaves in the same cycle. A grant is registered, which gives one
// cycle of arbitration latency. While a slave is owned, the owner's request
// goes to the slave with the address rebased to the window start. The slave's
// response goes to the owner and to no other master.
//
// Optional feature: define WB_XBAR_TIMEOUT_EN to add a per-slave watchdog.
// The watchdog aborts an owned transfer after TIMEOUT_CYC strobe cycles
// with no response, and returns err to the owner.
//
// Ports
//   clk_i, rstn_i           clock, asynchronous active-low reset
//   sstart_addr_i           per-slave window start (inclusive), N_SLAVE*AW
//   send_addr_i             per-slave window end (exclusive),   N_SLAVE*AW
//   m_adr/dat/sel/we/cyc/stb/lock_i   master requests (flattened per master)
//   m_dat/ack/err/rty/gnt_o           master responses and grant indication
//   s_adr/dat/sel/we/cyc/stb_o        slave requests (flattened per slave)
//   s_dat/ack/err/rty_i               slave responses
// -----------------------------------------------------------------------------
module wb_xbar_rr #(
  parameter int N_MASTER    = 2,
  parameter int N_SLAVE     = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [N_SLAVE*AW-1:0]    sstart_addr_i,
  input  logic [N_SLAVE*AW-1:0]    send_addr_i,
  input  logic [N_MASTER*AW-1:0]   m_adr_i,
  input  logic [N_MASTER*DW-1:0]   m_dat_i,
  input  logic [N_MASTER*DW/8-1:0] m_sel_i,
  input  logic [N_MASTER-1:0]      m_we_i,
  input  logic [N_MASTER-1:0]      m_cyc_i,
  input  logic [N_MASTER-1:0]      m_stb_i,
  input  logic [N_MASTER-1:0]      m_lock_i,
  output logic [N_MASTER*DW-1:0]   m_dat_o,
  output logic [N_MASTER-1:0]      m_ack_o,
  output logic [N_MASTER-1:0]      m_err_o,
  output logic [N_MASTER-1:0]      m_rty_o,
  output logic [N_MASTER-1:0]      m_gnt_o,
  output logic [N_SLAVE*AW-1:0]    s_adr_o,
  output logic [N_SLAVE*DW-1:0]    s_dat_o,
  output logic [N_SLAVE*DW/8-1:0]  s_sel_o,
  output logic [N_SLAVE-1:0]       s_we_o,
  output logic [N_SLAVE-1:0]       s_cyc_o,
  output logic [N_SLAVE-1:0]       s_stb_o,
  input  logic [N_SLAVE*DW-1:0]    s_dat_i,
  input  logic [N_SLAVE-1:0]       s_ack_i,
  input  logic [N_SLAVE-1:0]       s_err_i,
  input  logic [N_SLAVE-1:0]       s_rty_i
);

  localparam int SW = DW / 8;
  localparam int MW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_OWNED = 1'b1} arb_state_e;

  arb_state_e          state_q [N_SLAVE];
  arb_state_e          state_d [N_SLAVE];
  logic [MW-1:0]       owner_q [N_SLAVE];
  logic [MW-1:0]       owner_d [N_SLAVE];
  logic [MW-1:0]       ptr_q   [N_SLAVE];
  logic [MW-1:0]       ptr_d   [N_SLAVE];
  logic [N_SLAVE-1:0]  tmo_hit;
  logic [N_MASTER-1:0] dflt_err_q;
  logic                run_q;

  // Address decode: tgt[m] is one-hot on the hit slave, all-zero on a miss.
  logic [N_SLAVE-1:0]  tgt [N_MASTER];
  logic [N_MASTER-1:0] miss;

  always_comb begin
    for (int m = 0; m < N_MASTER; m++) begin
      tgt[m] = '0;
      // The loop runs downward so that the lowest matching slave is written last and wins.
      for (int k = N_SLAVE - 1; k >= 0; k--) begin
        if (m_adr_i[m*AW +: AW] >= sstart_addr_i[k*AW +: AW] &&
            m_adr_i[m*AW +: AW] <  send_addr_i[k*AW +: AW]) begin
          tgt[m]    = '0;
          tgt[m][k] = 1'b1;
        end
      end
      miss[m] = ~|tgt[m];
    end
  end

  // A master that holds a locked slave must not pick up a second slave.
  logic [N_MASTER-1:0] owns_any;
  logic [N_MASTER-1:0] locked;

  always_comb begin
    owns_any = '0;
    for (int k = 0; k < N_SLAVE; k++) begin
      if (state_q[k] == ARB_OWNED) owns_any[owner_q[k]] = 1'b1;
    end
    locked = owns_any & m_lock_i;
  end

  // Arbiter next state
  always_comb begin
    int   cand;
    int   o;
    logic found;
    for (int k = 0; k < N_SLAVE; k++) begin
      // NOTE: every combinational output gets a default before any branch; this prevents an inferred latch.
      state_d[k] = state_q[k];
      owner_d[k] = owner_q[k];
      ptr_d[k]   = ptr_q[k];
      found      = 1'b0;
      cand       = 0;
      o          = int'(owner_q[k]);
      unique case (state_q[k])
        ARB_IDLE: begin
          // Search starts one past the last winner and wraps modulo N_MASTER.
          for (int i = 1; i <= N_MASTER; i++) begin
            cand = (int'(ptr_q[k]) + i) % N_MASTER;
            if (!found && m_cyc_i[cand] && m_stb_i[cand] && tgt[cand][k] && !locked[cand]) begin
              found      = 1'b1;
              state_d[k] = ARB_OWNED;
              owner_d[k] = MW'(cand);
              ptr_d[k]   = MW'(cand);
            end
          end
        end
        ARB_OWNED: begin
          if (!m_cyc_i[o] ||
              (m_stb_i[o] && !tgt[o][k] && !m_lock_i[o]) ||
              tmo_hit[k]) begin
            state_d[k] = ARB_IDLE;
          end
        end
        default: state_d[k] = ARB_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < N_SLAVE; k++) begin
        state_q[k] <= ARB_IDLE;
        owner_q[k] <= '0;
        ptr_q[k]   <= MW'(N_MASTER - 1);
      end
      dflt_err_q <= '0;
      run_q      <= 1'b0;
    end else begin
      // NOTE: state is written with non-blocking assignments, so every flop samples values from before the edge.
      for (int k = 0; k < N_SLAVE; k++) begin
        state_q[k] <= state_d[k];
        owner_q[k] <= owner_d[k];
        ptr_q[k]   <= ptr_d[k];
      end
      // Default slave: at most one err per strobe. A strobe held high therefore gives a 1/0 pulse train.
      dflt_err_q <= m_cyc_i & m_stb_i & miss & ~m_err_o;
      run_q      <= 1'b1;
    end
  end

`ifdef WB_XBAR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt_q [N_SLAVE];

  always_comb begin
    for (int k = 0; k < N_SLAVE; k++) begin
      tmo_hit[k] = (state_q[k] == ARB_OWNED) && (tmo_cnt_q[k] == CW'(TIMEOUT_CYC));
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < N_SLAVE; k++) tmo_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_SLAVE; k++) begin
        if (state_q[k] != ARB_OWNED || state_d[k] == ARB_IDLE) tmo_cnt_q[k] <= '0;
        else if (s_ack_i[k] || s_err_i[k] || s_rty_i[k])       tmo_cnt_q[k] <= '0;
        else if (s_stb_o[k])                                   tmo_cnt_q[k] <= tmo_cnt_q[k] + CW'(1);
      end
    end
  end
`else
  // The watchdog is not built in. Its limit is still a legal parameter and is intentionally left unused.
  localparam int tmo_limit_unused = TIMEOUT_CYC;
  assign tmo_hit = '0;
`endif

  // Slave-side outputs: only an owned slave sees anything. A watchdog abort drops cyc and stb at once.
  always_comb begin
    int o;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = '0;
    s_cyc_o = '0;
    s_stb_o = '0;
    for (int k = 0; k < N_SLAVE; k++) begin
      o = int'(owner_q[k]);
      if (state_q[k] == ARB_OWNED) begin
        s_adr_o[k*AW +: AW] = m_adr_i[o*AW +: AW] - sstart_addr_i[k*AW +: AW];
        s_dat_o[k*DW +: DW] = m_dat_i[o*DW +: DW];
        s_sel_o[k*SW +: SW] = m_sel_i[o*SW +: SW];
        s_we_o[k]           = m_we_i[o];
        s_cyc_o[k]          = m_cyc_i[o] & ~tmo_hit[k];
        s_stb_o[k]          = m_stb_i[o] & ~tmo_hit[k];
      end
    end
  end

  // Master-side outputs. A response is routed only while its arbiter is OWNED, so a late ack from a released slave is dropped.
  always_comb begin
    int o;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    m_gnt_o = '0;
    for (int k = 0; k < N_SLAVE; k++) begin
      o = int'(owner_q[k]);
      if (state_q[k] == ARB_OWNED) begin
        m_dat_o[o*DW +: DW] = s_dat_i[k*DW +: DW];
        m_ack_o[o]          = s_ack_i[k];
        m_err_o[o]          = s_err_i[k] | tmo_hit[k];
        m_rty_o[o]          = s_rty_i[k];
        m_gnt_o[o]          = 1'b1;
      end
    end
    m_err_o = m_err_o | dflt_err_q;
    // Service by the default slave counts as a grant once the block is out of reset.
    m_gnt_o = m_gnt_o | (m_cyc_i & m_stb_i & miss & {N_MASTER{run_q}});
  end

endmodule

// File: tb/tb_wb_xbar_rr.sv
`timescale 1ns/1ps
// Testbench for wb_xbar_rr: two masters, two slaves. Slave 0 covers
// [0x0000,0x1000) and slave 1 covers [0x1000,0x2000). Expected master
// responses go into a queue when stimulus is issued. A monitor pops one entry
// for every ack/err/rty the DUT presents. Slave-side and grant values are
// compared directly against hand-computed constants.
module tb_wb_xbar_rr;
  localparam int NM = 2;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic [NS*AW-1:0]  sstart_addr_i, send_addr_i;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*SW-1:0]  m_sel_i;
  logic [NM-1:0]     m_we_i, m_cyc_i, m_stb_i, m_lock_i;
  logic [NM*DW-1:0]  m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o, m_gnt_o;
  logic [NS*AW-1:0]  s_adr_o;
  logic [NS*DW-1:0]  s_dat_o;
  logic [NS*SW-1:0]  s_sel_o;
  logic [NS-1:0]     s_we_o, s_cyc_o, s_stb_o;
  logic [NS*DW-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i, s_err_i, s_rty_i;

  wb_xbar_rr #(
    .N_MASTER(NM), .N_SLAVE(NS), .AW(AW), .DW(DW), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .sstart_addr_i(sstart_addr_i), .send_addr_i(send_addr_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_lock_i(m_lock_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .m_gnt_o(m_gnt_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          m;
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_m(input int m, input logic [31:0] adr, input logic cyc,
                         input logic stb, input logic lock);
    m_adr_i[m*AW +: AW] = adr;
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = stb;
    m_lock_i[m]         = lock;
  endtask

  task automatic set_s(input int k, input logic ack, input logic err, input logic [31:0] dat);
    s_ack_i[k]          = ack;
    s_err_i[k]          = err;
    s_dat_i[k*DW +: DW] = dat;
  endtask

  task automatic expect_resp(input int m, input logic ack, input logic err, input logic [31:0] dat);
    exp_t e;
    e.m   = m;
    e.ack = ack;
    e.err = err;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] sadr(input int k);
    return s_adr_o[k*AW +: AW];
  endfunction

  function automatic logic [31:0] mdat(input int m);
    return m_dat_o[m*DW +: DW];
  endfunction

  // Response monitor: one queue entry per master response, in master order.
  always @(negedge clk_i) begin
    exp_t e;
    for (int m = 0; m < NM; m++) begin
      if (m_ack_o[m] || m_err_o[m] || m_rty_o[m]) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp m%0d: ack=%b err=%b rty=%b, expected no response",
                   m, m_ack_o[m], m_err_o[m], m_rty_o[m]);
        end else begin
          e = exp_q.pop_front();
          check("resp_master", 64'(m), 64'(e.m));
          check("resp_ack", 64'(m_ack_o[m]), 64'(e.ack));
          check("resp_err", 64'(m_err_o[m]), 64'(e.err));
          check("resp_rty", 64'(m_rty_o[m]), 64'd0);
          if (e.ack) check("resp_dat", 64'(mdat(m)), 64'(e.dat));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    sstart_addr_i = {32'h0000_1000, 32'h0000_0000};
    send_addr_i   = {32'h0000_2000, 32'h0000_1000};
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_lock_i = '0;
    s_dat_i = '0; s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
    rstn_i  = 1'b0;

    // Reset: a miss request is held through reset, and every output stays quiet.
    drive_m(0, 32'h5000, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    check("rst_s_stb", 64'(s_stb_o), 64'd0);
    check("rst_m_gnt", 64'(m_gnt_o), 64'd0);
    check("rst_m_err", 64'(m_err_o), 64'd0);
    check("rst_m_ack", 64'(m_ack_o), 64'd0);
    drive_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rstn_i = 1'b1;

    // T1: M0 reads 0x1004. It is rebased onto slave1, and the ack returns DEADBEEF.
    drive_m(0, 32'h1004, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    check("t1_arb_latency", 64'(s_stb_o), 64'd0);
    tick();
    @(negedge clk_i);
    check("t1_s1_stb", 64'(s_stb_o), 64'b10);
    check("t1_s1_adr", 64'(sadr(1)), 64'h4);
    check("t1_gnt", 64'(m_gnt_o), 64'b01);
    tick();
    set_s(1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    expect_resp(0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();
    set_s(1, 1'b0, 1'b0, 32'h0);
    drive_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clk_i);
    check("t1_release_cyc", 64'(s_cyc_o), 64'd0);
    check("t1_release_gnt", 64'(m_gnt_o), 64'd0);

    // T2: M0 and M1 contend for slave0. M0 wins first, then M1 wins by round-robin.
    drive_m(0, 32'h10, 1'b1, 1'b1, 1'b0);
    drive_m(1, 32'h20, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk_i);
    check("t2_first_gnt", 64'(m_gnt_o), 64'b01);
    check("t2_first_adr", 64'(sadr(0)), 64'h10);
    tick();
    set_s(0, 1'b1, 1'b0, 32'h1111_1111);
    expect_resp(0, 1'b1, 1'b0, 32'h1111_1111);
    tick();
    set_s(0, 1'b0, 1'b0, 32'h0);
    drive_m(0, 32'h10, 1'b0, 1'b0, 1'b0);
    tick();
    drive_m(0, 32'h10, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    check("t2_idle_gap", 64'(m_gnt_o), 64'd0);
    tick();
    @(negedge clk_i);
    check("t2_rr_gnt", 64'(m_gnt_o), 64'b10);
    check("t2_rr_adr", 64'(sadr(0)), 64'h20);
    tick();
    set_s(0, 1'b1, 1'b0, 32'h2222_2222);
    expect_resp(1, 1'b1, 1'b0, 32'h2222_2222);
    tick();
    set_s(0, 1'b0, 1'b0, 32'h0);
    drive_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive_m(1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();

    // T3: concurrent accesses. M0 reads slave0 while M1 writes slave1.
    drive_m(0, 32'h100, 1'b1, 1'b1, 1'b0);
    drive_m(1, 32'h1200, 1'b1, 1'b1, 1'b0);
    m_we_i[1] = 1'b1;
    m_dat_i[DW +: DW] = 32'hCAFE_F00D;
    m_sel_i[SW +: SW] = 4'hF;
    tick();
    @(negedge clk_i);
    check("t3_gnt", 64'(m_gnt_o), 64'b11);
    check("t3_cyc", 64'(s_cyc_o), 64'b11);
    check("t3_adr0", 64'(sadr(0)), 64'h100);
    check("t3_adr1", 64'(sadr(1)), 64'h200);
    check("t3_we", 64'(s_we_o), 64'b10);
    check("t3_wdat", 64'(s_dat_o), {32'hCAFE_F00D, 32'h0});
    check("t3_sel", 64'(s_sel_o), 64'hF0);
    tick();
    set_s(0, 1'b1, 1'b0, 32'hAAAA_0000);
    set_s(1, 1'b1, 1'b0, 32'hBBBB_1111);
    expect_resp(0, 1'b1, 1'b0, 32'hAAAA_0000);
    expect_resp(1, 1'b1, 1'b0, 32'hBBBB_1111);
    tick();
    set_s(0, 1'b0, 1'b0, 32'h0);
    set_s(1, 1'b0, 1'b0, 32'h0);
    drive_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive_m(1, 32'h0, 1'b0, 1'b0, 1'b0);
    m_we_i = '0; m_dat_i = '0; m_sel_i = '0;
    tick();

    // T4: unmapped address. Err comes from the default slave one cycle later, and no slave cycle is started.
    drive_m(0, 32'h5000, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    check("t4_no_s_cyc", 64'(s_cyc_o), 64'd0);
    check("t4_gnt_dflt", 64'(m_gnt_o), 64'b01);
    check("t4_err_not_yet", 64'(m_err_o), 64'd0);
    expect_resp(0, 1'b0, 1'b1, 32'h0);
    tick();
    drive_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    check("t4_no_s_cyc_err", 64'(s_cyc_o), 64'd0);
    tick();
    @(negedge clk_i);
    check("t4_err_pulse_end", 64'(m_err_o), 64'd0);

    // T5: a late ack from a released slave must not reach anyone.
    drive_m(0, 32'h1008, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk_i);
    check("t5_own_s1", 64'(s_cyc_o), 64'b10);
    tick();
    drive_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive_m(1, 32'h40, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk_i);
    check("t5_s1_released", 64'(s_cyc_o), 64'b01);
    check("t5_gnt_m1", 64'(m_gnt_o), 64'b10);
    tick();
    set_s(1, 1'b1, 1'b0, 32'hBADB_AD00);
    @(negedge clk_i);
    check("t5_late_ack", 64'(m_ack_o), 64'd0);
    check("t5_late_dat_m1", 64'(mdat(1)), 64'd0);
    tick();
    set_s(1, 1'b0, 1'b0, 32'h0);
    drive_m(1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();

    // T6: lock keeps slave0 while stb points elsewhere. A stb drop keeps ownership. Unlocking moves M0 to slave1.
    drive_m(0, 32'h80, 1'b1, 1'b1, 1'b1);
    tick();
    @(negedge clk_i);
    check("t6_own_s0", 64'(s_cyc_o), 64'b01);
    tick();
    drive_m(0, 32'h1080, 1'b1, 1'b1, 1'b1);
    tick();
    @(negedge clk_i);
    check("t6_lock_persist", 64'(s_cyc_o), 64'b01);
    check("t6_lock_gnt", 64'(m_gnt_o), 64'b01);
    tick();
    drive_m(0, 32'h1080, 1'b1, 1'b0, 1'b1);
    @(negedge clk_i);
    check("t6_stb_low_s_stb", 64'(s_stb_o), 64'd0);
    check("t6_stb_low_s_cyc", 64'(s_cyc_o), 64'b01);
    tick();
    @(negedge clk_i);
    check("t6_stb_low_kept", 64'(s_cyc_o), 64'b01);
    tick();
    drive_m(0, 32'h1080, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk_i);
    check("t6_unlock_move", 64'(s_cyc_o), 64'b10);
    check("t6_unlock_adr", 64'(sadr(1)), 64'h80);
    tick();
    drive_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();

    // T7: reset mid-transfer drops the slave cycle with no clock edge. The pointers restart at master 0.
    drive_m(1, 32'h1010, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk_i);
    check("t7_own", 64'(s_cyc_o), 64'b10);
    #2 rstn_i = 1'b0;
    #1;
    check("t7_async_cyc", 64'(s_cyc_o), 64'd0);
    check("t7_async_stb", 64'(s_stb_o), 64'd0);
    check("t7_async_gnt", 64'(m_gnt_o), 64'd0);
    tick();
    rstn_i = 1'b1;
    drive_m(0, 32'h30, 1'b1, 1'b1, 1'b0);
    drive_m(1, 32'h34, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk_i);
    check("t7_ptr_reset_gnt", 64'(m_gnt_o), 64'b01);
    tick();
    drive_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive_m(1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

`ifdef WB_XBAR_TIMEOUT_EN
    // T8: slave0 never answers. Err arrives after the 8th unanswered strobe cycle, and then the slave is released.
    drive_m(0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      check("t8_stb_pending", 64'(s_stb_o[0]), 64'd1);
      tick();
    end
    expect_resp(0, 1'b0, 1'b1, 32'h0);
    @(negedge clk_i);
    check("t8_tmo_cyc_drop", 64'(s_cyc_o[0]), 64'd0);
    tick();
    drive_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    check("t8_idle_after", 64'(s_cyc_o), 64'd0);
    tick();
`else
    // T8: with no watchdog built in, a silent slave keeps its owner indefinitely.
    drive_m(0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    repeat (20) tick();
    @(negedge clk_i);
    check("t8_silent_hold_cyc", 64'(s_cyc_o), 64'b01);
    check("t8_silent_hold_gnt", 64'(m_gnt_o), 64'b01);
    tick();
    drive_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
`endif

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
